// File: rtl/memory_mapped_io_uart_rx_pkg.sv
// Shared constants for the UART RX MMIO peripheral: register offsets and serial FSM states.
package memory_mapped_io_uart_rx_pkg;

    localparam logic [31:0] UART_RX_QUEUE_HEAD_OFFSET = 32'h0000_0100;
    localparam logic [31:0] UART_RX_QUEUE_TAIL_OFFSET = 32'h0000_0104;
    localparam logic [31:0] UART_RX_STATUS_OFFSET     = 32'h0000_0108;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/memory_mapped_io_uart_rx_core.sv
// 8N1 deserialiser: 2-flop synchroniser, mid-bit sampling, one-cycle data_valid / framing_error pulses.
// CLKS_PER_BIT must be >= 4.
module uart_rx_core
    import memory_mapped_io_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       data_valid,
    output logic [7:0] data,
    output logic       framing_error
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic rx_meta, rx_sync;
    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shift, shift_n;

    // Synchroniser starts high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        bit_idx_n     = bit_idx;
        shift_n       = shift;
        data_valid    = 1'b0;
        framing_error = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    state_n = RX_START;
                    cnt_n   = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_sync;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else                 bit_idx_n = bit_idx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_sync) begin
                        data_valid = 1'b1;
                        state_n    = RX_IDLE;
                    end else begin
                        framing_error = 1'b1;
                        state_n       = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign data = shift;

endmodule

// File: rtl/memory_mapped_io_uart_rx.sv
// MMIO UART receiver: 256-byte circular buffer (64 x 32-bit words), CPU-owned head, hardware tail.
// Optional sticky W1C error status under `UART_RX_ERROR_STATUS_EN.
module memory_mapped_io_uart_rx
    import memory_mapped_io_uart_rx_pkg::*;
#(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic        input_cmd_start,
    input  logic        input_cmd_write,
    output logic        output_cmd_ready,
    input  logic [31:0] input_addr,
    output logic [31:0] output_rdata,
    output logic        output_rdata_valid,
    input  logic [31:0] input_wdata
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

    logic [31:0] buffer [64];
    logic [7:0]  queue_head, queue_tail, tail_next;
    logic [1:0]  status;
    logic        rx_valid, rx_ferr, full, push, overrun, wr_cmd;
    logic [7:0]  rx_data;
    logic        unused_wdata;

    assign output_cmd_ready   = 1'b1;
    assign output_rdata_valid = 1'b1;
    assign unused_wdata       = &{1'b0, input_wdata[31:8]};

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .data_valid    (rx_valid),
        .data          (rx_data),
        .framing_error (rx_ferr)
    );

    // Full is judged against the pre-write head, so a same-cycle head write cannot free a slot.
    assign tail_next = queue_tail + 8'd1;
    assign full      = (tail_next == queue_head);
    assign push      = rx_valid && !full;
    assign overrun   = rx_valid && full;
    assign wr_cmd    = input_cmd_start && input_cmd_write;

    always_ff @(posedge clk) begin
        if (push) buffer[queue_tail[7:2]][{queue_tail[1:0], 3'b000} +: 8] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            queue_head <= '0;
            queue_tail <= '0;
        end else begin
            if (wr_cmd && input_addr == UART_RX_QUEUE_HEAD_OFFSET) queue_head <= input_wdata[7:0];
            if (push) queue_tail <= tail_next;
        end
    end

`ifdef UART_RX_ERROR_STATUS_EN
    logic [1:0] status_clr;
    assign status_clr = (wr_cmd && input_addr == UART_RX_STATUS_OFFSET) ? input_wdata[1:0] : 2'b00;

    // Set wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) status <= '0;
        else       status <= (status & ~status_clr) | {rx_ferr, overrun};
    end
`else
    logic unused_events;
    assign unused_events = &{1'b0, rx_ferr, overrun};
    assign status        = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            output_rdata <= '0;
        end else begin
            case (input_addr)
                UART_RX_QUEUE_HEAD_OFFSET: output_rdata <= {24'b0, queue_head};
                UART_RX_QUEUE_TAIL_OFFSET: output_rdata <= {24'b0, queue_tail};
                UART_RX_STATUS_OFFSET:     output_rdata <= {30'b0, status};
                default:                   output_rdata <= buffer[input_addr[7:2]];
            endcase
        end
    end

endmodule

// File: doc/memory_mapped_io_uart_rx.md
Name: memory_mapped_io_uart_rx

Overview:
- Memory-mapped UART receiver; the receive-side counterpart of the UART TX queue peripheral.
- Deserialises 8N1 frames from the uart_rx pin and appends each byte to a 256-byte circular buffer.
- The buffer is stored as 64 x 32-bit words. Hardware advances queue_tail; the CPU reads buffer words, then advances queue_head by writing it.
- Sits on the same MMIO command bus as the TX peripheral.

Parameters:
- CLK_FREQ, 27000000, core clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT is derived: CLK_FREQ/BAUD_RATE, integer division; must be >= 4.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  serial input; idle high; asynchronous to clk.
- input_cmd_start  input  1  command valid.
- input_cmd_write  input  1  1 = write, 0 = read.
- output_cmd_ready  output  1  tied to 1.
- input_addr  input  32  peripheral-local byte address.
- output_rdata  output  32  read data, registered.
- output_rdata_valid  output  1  tied to 1.
- input_wdata  input  32  write data.

Behaviour:
Clock and reset
- One clock, clk. Reset is synchronous and active-high on the port named reset.
- Reset clears output_rdata, queue_head, queue_tail and status flags to 0, and sends the serial FSM to IDLE. Buffer contents are not reset.
- A frame in progress when reset asserts is discarded.

Address map (constants in memorymap include)
- UART_RX_QUEUE_HEAD_OFFSET = 0x100
- UART_RX_QUEUE_TAIL_OFFSET = 0x104
- UART_RX_STATUS_OFFSET = 0x108
- Any other address is a buffer access, word index input_addr[7:2].

Bus behaviour
- Reads: every cycle, output_rdata <= selected value (buffer word, {24'b0, head}, {24'b0, tail}, or status). Latency is 1 cycle; no stall.
- Writes (input_cmd_start & input_cmd_write):
  - head offset: queue_head <= input_wdata[7:0].
  - tail offset and buffer addresses: ignored; buffer is hardware-write-only.
  - status offset: see Optional Feature.

Serial receiver FSM (8N1)
- uart_rx passes through a 2-flop synchroniser, initialised high.
- IDLE: on synchronised low -> START, counter = 0.
- START: at count CLKS_PER_BIT/2 recheck the line.
  - Still low -> DATA, counter = 0, bit = 0.
  - Otherwise glitch -> IDLE.
- DATA: every CLKS_PER_BIT clocks, sample into shift[bit], LSB first. After bit 7 -> STOP.
- STOP: after CLKS_PER_BIT, sample the line.
  - High -> push byte, -> IDLE.
  - Low -> framing error: byte dropped, wait for line high, -> IDLE.

Push
- Byte lane queue_tail[1:0] of buffer[queue_tail[7:2]] is written; other lanes are preserved.
- queue_tail <= queue_tail + 1, 8-bit wrap-around (0xFF -> 0x00).
- Full when (queue_tail + 1) == queue_head: byte dropped, tail unchanged, overrun event raised. Capacity is 255 bytes.
- Empty when head == tail.

Simultaneous events
- Push and CPU head write in the same cycle: full is evaluated against the old head; the head write still takes effect.
- Bus read of the word being pushed in the same cycle returns the old word.
- Bus read of tail in the push cycle returns the old tail.

Optional Feature:
- Macro UART_RX_ERROR_STATUS_EN.
- Defined: status register with bit0 = overrun, bit1 = framing error. Both bits are sticky, set on the event and cleared by writing 1 to the bit (W1C). If set and clear happen in the same cycle, set wins.
- Undefined: status reads as 0 and writes are ignored; dropping behaviour is unchanged.

Decomposition:
- Shared include/package: offset constants alongside the TX offsets; FSM state localparams.
- Sub-module uart_rx_core: synchroniser, bit timing and FSM. Outputs a data_valid pulse, data[7:0], and framing_error pulse.
- The MMIO wrapper owns the buffer, pointers and status.

Test Plan (CLK_FREQ=100, BAUD_RATE=10):
- Send 0x41 then 0x42 -> tail reads 2, head 0; word 0 lanes [15:0] read 0x4241, 1 cycle after the address is applied.
- Set head=0xFE and tail=0xFE by sending bytes, then send 0x10, 0x20 -> tail becomes 0x00; lanes 2 and 3 of word 63 read 0x10 and 0x20.
- Fill 255 bytes without advancing head, then send 0x55 -> tail stays at head-1, 0x55 absent; status bit0 = 1 (feature on). Write 0x1 to status -> status 0.
- Frame with stop bit low (data 0xAA) -> tail unchanged; status bit1 = 1.
- Low glitch of 2 clocks on uart_rx -> no push, FSM back to IDLE; next valid frame 0x33 is received correctly.
- Assert reset mid-frame at data bit 3 -> head, tail, output_rdata and status are 0; the following frame 0x7E is received intact at buffer byte 0.
